// File: rtl/icache_2way.sv
// rtl/icache_2way.sv - read-only 2-way set-associative L1 instruction cache with LRU replacement
module icache_2way #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic [31:0]  mem_address,
    input  logic         mem_stall,
    output logic         mem_resp,
    output logic         mem_ready,
    output logic [31:0]  mem_rdata,
    output logic         pmem_read,
    output logic [31:0]  pmem_address,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [0:0] {IDLE, FILL} state_t;

    state_t state;
    state_t state_next;

    logic [TAG_W-1:0] tag_arr  [2][SETS];
    logic [255:0]     line_arr [2][SETS];
    logic [SETS-1:0]  valid0;
    logic [SETS-1:0]  valid1;
    logic [SETS-1:0]  lru;

    // Line-aligned fill address; the low five byte-offset bits are implicit zeros.
    logic [26:0] fill_line;

    logic [2:0]         word;
    logic [S_INDEX-1:0] idx;
    logic [TAG_W-1:0]   tg;
    logic [S_INDEX-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit0;
    logic               hit1;
    logic               hit;
    logic [255:0]       hit_line;
    logic [31:0]        hit_word;
    logic               victim;
    logic               fill_done;
    logic               hit_update;
    logic               start_fill;
    logic               addr_unused;

    assign word        = mem_address[4:2];
    assign idx         = mem_address[4+S_INDEX:5];
    assign tg          = mem_address[31:5+S_INDEX];
    assign addr_unused = &{1'b0, mem_address[1:0]};
    assign fill_idx    = fill_line[S_INDEX-1:0];
    assign fill_tag    = fill_line[26:S_INDEX];

    assign hit0     = valid0[idx] && (tag_arr[0][idx] == tg);
    assign hit1     = valid1[idx] && (tag_arr[1][idx] == tg);
    assign hit      = hit0 || hit1;
    assign hit_line = hit1 ? line_arr[1][idx] : line_arr[0][idx];
    assign hit_word = hit_line[{word, 5'b0} +: 32];

    assign victim     = lru[fill_idx];
    assign fill_done  = (state == FILL) && pmem_resp;
    assign hit_update = (state == IDLE) && mem_read && hit && !mem_stall;
    assign start_fill = (state == IDLE) && mem_read && !hit && !mem_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_fill) state_next = FILL;
            FILL:    if (pmem_resp)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_ready    = 1'b0;
        mem_resp     = 1'b0;
        mem_rdata    = 32'h0;
        pmem_read    = 1'b0;
        pmem_address = {fill_line, 5'b0};
        case (state)
            IDLE: begin
                mem_ready = 1'b1;
                mem_resp  = mem_read && hit;
                mem_rdata = (mem_read && hit) ? hit_word : 32'h0;
            end
            FILL: begin
                pmem_read = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_line <= '0;
        end else if (start_fill) begin
            fill_line <= mem_address[31:5];
        end
    end

    // Victim choice looks only at LRU, never at valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else if (fill_done) begin
            if (victim) begin
                valid1[fill_idx] <= 1'b1;
            end else begin
                valid0[fill_idx] <= 1'b1;
            end
            lru[fill_idx] <= ~victim;
        end else if (hit_update) begin
            lru[idx] <= ~hit1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            line_arr[victim][fill_idx] <= pmem_rdata;
            tag_arr[victim][fill_idx]  <= fill_tag;
        end
    end

endmodule

// File: tb/tb_icache_2way.sv
// tb/tb_icache_2way.sv - directed self-checking bench for icache_2way
module tb_icache_2way;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_read = 1'b0;
    logic [31:0]  mem_address = 32'h0;
    logic         mem_stall = 1'b0;
    logic         mem_resp;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    icache_2way #(.S_INDEX(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_stall    (mem_stall),
        .mem_resp     (mem_resp),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    // Memory contents: each word encodes its own byte address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            l[32*k +: 32] = word_of({a[31:5], 5'b0} + 32'(4 * k));
        end
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", name, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_miss(input logic [31:0] a, input int lat);
        mem_read = 1'b1; mem_address = a; mem_stall = 1'b0;
        #1;
        chk("miss_detect_resp", 32'(mem_resp), 32'd0);
        chk("miss_detect_pread", 32'(pmem_read), 32'd0);
        tick();
        for (int i = 0; i < lat; i++) begin
            if (i == lat - 1) begin
                pmem_resp = 1'b1; pmem_rdata = line_of(a);
            end
            #1;
            chk("fill_pread", 32'(pmem_read), 32'd1);
            chk("fill_paddr", pmem_address, {a[31:5], 5'b0});
            chk("fill_ready", 32'(mem_ready), 32'd0);
            chk("fill_resp", 32'(mem_resp), 32'd0);
            tick();
            pmem_resp = 1'b0; pmem_rdata = {8{32'hDEAD_BEEF}};
        end
        #1;
        chk("served_resp", 32'(mem_resp), 32'd1);
        chk("served_rdata", mem_rdata, word_of(a));
        chk("served_pread", 32'(pmem_read), 32'd0);
        tick();
    endtask

    task automatic expect_hit(input logic [31:0] a);
        mem_read = 1'b1; mem_address = a; mem_stall = 1'b0;
        #1;
        chk("hit_resp", 32'(mem_resp), 32'd1);
        chk("hit_rdata", mem_rdata, word_of(a));
        chk("hit_pread", 32'(pmem_read), 32'd0);
        tick();
    endtask

    initial begin
        tick();
        chk("rst_ready", 32'(mem_ready), 32'd1);
        chk("rst_resp", 32'(mem_resp), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_pread", 32'(pmem_read), 32'd0);
        rst = 1'b0;
        tick();

        // First fill with a 3-cycle memory, then sweep the rest of the line.
        do_miss(32'h0000_0040, 3);
        for (int k = 1; k < 8; k++) begin
            expect_hit(32'h0000_0040 + 32'(4 * k));
        end

        // Three tags competing for set 0.
        do_miss(32'h0000_0000, 1);
        do_miss(32'h0000_0100, 2);
        expect_hit(32'h0000_0000);
        do_miss(32'h0000_0200, 1);
        expect_hit(32'h0000_0000);
        do_miss(32'h0000_0100, 1);
        expect_hit(32'h0000_0000);

        // Address and stall change mid-fill are ignored.
        mem_read = 1'b1; mem_address = 32'h0000_0080; mem_stall = 1'b0;
        #1;
        chk("chg_detect_resp", 32'(mem_resp), 32'd0);
        tick();
        mem_address = 32'h0000_00C0; mem_stall = 1'b1;
        #1;
        chk("chg_paddr1", pmem_address, 32'h0000_0080);
        chk("chg_ready1", 32'(mem_ready), 32'd0);
        tick();
        mem_stall = 1'b0; pmem_resp = 1'b1; pmem_rdata = line_of(32'h0000_0080);
        #1;
        chk("chg_paddr2", pmem_address, 32'h0000_0080);
        chk("chg_pread2", 32'(pmem_read), 32'd1);
        tick();
        pmem_resp = 1'b0;
        do_miss(32'h0000_00C0, 2);
        expect_hit(32'h0000_0084);

        // Miss held off by stall for 4 cycles, then fill starts.
        mem_read = 1'b1; mem_address = 32'h0000_01E0; mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_pread", 32'(pmem_read), 32'd0);
            chk("stall_resp", 32'(mem_resp), 32'd0);
            chk("stall_ready", 32'(mem_ready), 32'd1);
            tick();
        end
        do_miss(32'h0000_01E0, 2);

        // Reset in the middle of a fill followed by a stray response.
        mem_read = 1'b1; mem_address = 32'h0000_03A0; mem_stall = 1'b0;
        tick();
        #1;
        chk("rfill_pread", 32'(pmem_read), 32'd1);
        rst = 1'b1;
        #1;
        chk("rfill_async_pread", 32'(pmem_read), 32'd0);
        chk("rfill_async_ready", 32'(mem_ready), 32'd1);
        tick();
        rst = 1'b0; mem_read = 1'b0;
        pmem_resp = 1'b1; pmem_rdata = line_of(32'h0000_03A0);
        tick();
        pmem_resp = 1'b0;
        #1;
        chk("stray_pread", 32'(pmem_read), 32'd0);
        mem_read = 1'b1; mem_address = 32'h0000_0040;
        #1;
        chk("post_rst_old_miss", 32'(mem_resp), 32'd0);
        mem_read = 1'b0;
        tick();
        do_miss(32'h0000_03A0, 2);
        expect_hit(32'h0000_03BC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/icache_2way.md
Name: icache_2way

Overview:
- Read-only, 2-way set-associative L1 instruction cache with LRU replacement.
- Sits directly downstream of the CPU datapath's I-mem port: imem_read, imem_address, imem_stall, imem_resp, imem_ready and imem_rdata connect one-to-one to the mem_* ports.
- Refills 256-bit lines from the physical-memory/arbiter side via a single-request, single-response handshake.
- Hits return data combinationally in the same cycle, so the datapath's pipe signal can advance every cycle on hits.

Parameters:
- S_INDEX, 3, log2 of number of sets (default 8 sets × 2 ways × 32 B = 512 B).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  fetch request (datapath imem_read).
- mem_address  in  32  fetch byte address; bits [1:0] ignored.
- mem_stall  in  1  consumer frozen; suppresses new fills and LRU updates.
- mem_resp  out  1  mem_rdata valid for mem_address this cycle.
- mem_ready  out  1  cache idle and able to look up (0 during fill).
- mem_rdata  out  32  instruction word.
- pmem_read  out  1  line fill request.
- pmem_address  out  32  line-aligned fill address, bits [4:0] = 0.
- pmem_rdata  in  256  fill line; word k at bits [32k+31:32k].
- pmem_resp  in  1  one-cycle pulse; pmem_rdata valid.

Behaviour:
- Address split:
  - word = addr[4:2]
  - index = addr[4+S_INDEX:5]
  - tag = addr[31:5+S_INDEX]
- Per set:
  - two ways, each with valid bit, tag and 256-bit line;
  - one LRU bit naming the way to replace next.
- Reset (async, any state):
  - state = IDLE; all valid = 0; all LRU = 0.
  - pmem_read = 0, mem_resp = 0, mem_ready = 1, mem_rdata = 0.
  - Line/tag arrays need no reset.
- hit_w = valid[w][index] & tag[w][index]==tag; hit = hit_0 | hit_1. Both ways never hold the same tag.
- State IDLE:
  - mem_ready = 1.
  - mem_resp = mem_read & hit; mem_rdata = word of hitting way, else 0.
  - On mem_read & hit & ~mem_stall: LRU[index] <= ~hit_way.
  - On mem_read & ~hit & ~mem_stall: latch fill_addr = {mem_address[31:5], 5'b0}, go to FILL.
  - On miss with mem_stall = 1: stay in IDLE, no fill.
  - On mem_read = 0: no state change.
- State FILL:
  - pmem_read = 1, pmem_address = fill_addr, held constant until pmem_resp.
  - mem_resp = 0, mem_ready = 0, mem_rdata = 0; mem_address/mem_stall changes are ignored.
  - On pmem_resp, for victim way v = LRU[fill index]:
    - line[v] <= pmem_rdata, tag[v] <= fill tag, valid[v] <= 1;
    - LRU <= ~v; go to IDLE.
  - pmem_read deasserts the cycle after pmem_resp.
- Miss latency: the request is hit-served in IDLE on the cycle after pmem_resp. Total = 1 (miss detect) + memory latency + 1.
- pmem_resp while in IDLE (e.g. after reset mid-fill) is ignored.
- Victim selection ignores valid bits. Only the LRU bit chooses; after reset, way 0 fills first, then way 1.
- Only one outstanding fill; no prefetch; no writes ever issued.

Test Plan:
- Reset, mem_read=1, addr 0x0000_0040, pmem responds 3 cycles after pmem_read:
  - pmem_read=1 with pmem_address=0x40 for exactly 3 cycles;
  - mem_resp=1 on the cycle after pmem_resp;
  - mem_rdata = pmem word 0.
- After that fill, sweep addr 0x44..0x5C: mem_resp=1 every cycle, mem_rdata = words 1..7, pmem_read stays 0.
- 3-way conflict:
  - 0x000 and 0x100 both fill set 0 (way0, way1); re-read 0x000 (LRU→way1);
  - 0x200 misses and evicts way1 (0x100);
  - then 0x000 hits and 0x100 misses.
- Miss on 0x80 with mem_stall=1 for 4 cycles: pmem_read stays 0, mem_resp=0; on stall drop, fill starts next cycle.
- Address changes 0x80→0xC0 mid-FILL: pmem_address stays 0x80; after the fill, 0xC0 misses and starts a second fill.
- Assert rst mid-FILL, then a stray pmem_resp: pmem_read=0 immediately, no line installed, and re-read of the fill address misses.
